// File: rtl/bp_fe_queue_fifo_pkg.sv
// Shared types and widths for the FE->BE checkpointed queue.
// bp_fe_queue_s is a local stand-in for the FE/BE interface packet.
package bp_fe_queue_fifo_pkg;

  localparam int unsigned vaddr_width_gp = 39;
  localparam int unsigned instr_width_gp = 32;
  localparam int unsigned exc_width_gp   = 4;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e           msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
    logic [exc_width_gp-1:0]     exc_code;
  } bp_fe_queue_s;

  localparam int unsigned fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_fe_queue_fifo_if.sv
// FE enqueue / BE dequeue-commit-rollback signal bundle for bp_fe_queue_fifo.
interface bp_fe_queue_fifo_if;
  import bp_fe_queue_fifo_pkg::*;

  bp_fe_queue_s fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  bp_fe_queue_s fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         commit_v_i;
  logic         roll_v_i;
  logic         clr_v_i;
  logic         empty_o;

  // FE + BE side driving the queue
  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
  );

  // The queue itself
  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
  );

endinterface

// File: rtl/bp_fe_queue_fifo_ptr.sv
// Wrap-bit circular pointer: load has priority over increment, async active-low reset.
module bp_fe_queue_ptr #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_fe_queue_fifo.sv
// Checkpointed FE->BE queue: speculative dequeue, free on commit, rollback and clear.
// Define BP_FE_QUEUE_BYPASS_EN for same-cycle enqueue-to-output forwarding when empty.
module bp_fe_queue_fifo
  import bp_fe_queue_fifo_pkg::*;
#(
  parameter int unsigned els_p = 8
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bp_fe_queue_fifo_if.slave  q_if
);

  localparam int unsigned idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned ptr_width_lp = idx_width_lp + 1;

  logic [ptr_width_lp-1:0] wptr_q, rptr_q, cptr_q;
  logic [ptr_width_lp-1:0] cptr_n, rptr_load_val;
  logic                    full, enq, deq, commit, roll, rptr_load;
  logic                    rd_v;
  bp_fe_queue_s            rd_data;
  bp_fe_queue_s            mem_q [els_p];

  // Same index with differing wrap bits means every slot holds an uncommitted entry
  assign full = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
             && (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0]);

  assign q_if.fe_queue_ready_o = ~full & ~q_if.clr_v_i;
  assign q_if.empty_o          = (wptr_q == cptr_q);

  assign enq    = q_if.fe_queue_v_i & q_if.fe_queue_ready_o;
  assign roll   = q_if.roll_v_i & ~q_if.clr_v_i;
  assign commit = q_if.commit_v_i & ~q_if.clr_v_i;
  assign deq    = q_if.fe_queue_yumi_i & rd_v & ~q_if.roll_v_i & ~q_if.clr_v_i;

  // Rollback lands on the post-commit pointer so a same-cycle commit is honoured
  assign cptr_n        = commit ? (cptr_q + ptr_width_lp'(1)) : cptr_q;
  assign rptr_load     = q_if.clr_v_i | roll;
  assign rptr_load_val = q_if.clr_v_i ? wptr_q : cptr_n;

`ifdef BP_FE_QUEUE_BYPASS_EN
  logic byp;
  assign byp     = (rptr_q == wptr_q) & enq & ~q_if.roll_v_i;
  assign rd_v    = (rptr_q != wptr_q) | byp;
  assign rd_data = byp ? q_if.fe_queue_i : mem_q[rptr_q[idx_width_lp-1:0]];
`else
  assign rd_v    = (rptr_q != wptr_q);
  assign rd_data = mem_q[rptr_q[idx_width_lp-1:0]];
`endif

  assign q_if.fe_queue_v_o = rd_v;
  assign q_if.fe_queue_o   = rd_data;

  // Storage: one write port, asynchronous read, deliberately not reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= q_if.fe_queue_i;
    end
  end

  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) u_wptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (enq),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (wptr_q)
  );

  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) u_rptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (deq),
    .load_i     (rptr_load),
    .load_val_i (rptr_load_val),
    .ptr_o      (rptr_q)
  );

  bp_fe_queue_ptr #(.width_p(ptr_width_lp)) u_cptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (commit),
    .load_i     (q_if.clr_v_i),
    .load_val_i (wptr_q),
    .ptr_o      (cptr_q)
  );

`ifndef SYNTHESIS
  logic [ptr_width_lp-1:0] rd_occ, wr_occ;
  assign rd_occ = rptr_q - cptr_q;
  assign wr_occ = wptr_q - cptr_q;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    q_if.fe_queue_yumi_i |-> q_if.fe_queue_v_o);

  a_commit_needs_deq: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q_if.commit_v_i & ~q_if.clr_v_i) |-> (cptr_q != rptr_q));

  // cptr <= rptr <= wptr in modular order, never more than els_p outstanding
  a_ptr_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (rd_occ <= wr_occ) && (wr_occ <= ptr_width_lp'(els_p)));
`endif

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// Directed test of bp_fe_queue_fifo: reset, fill/wrap, rollback, roll+commit, clear, bypass.
module tb_bp_fe_queue_fifo;
  import bp_fe_queue_fifo_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   errors = 0;
  int   checks = 0;

  localparam logic [38:0] base_pc = 39'h0_8000_0000;

  always #5 clk_i = ~clk_i;

  bp_fe_queue_fifo_if q_if ();

  bp_fe_queue_fifo #(.els_p(8)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .q_if      (q_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bp_fe_queue_s mk(input logic [38:0] pc);
    bp_fe_queue_s p;
    p.msg_type = e_fe_fetch;
    p.pc       = pc;
    p.instr    = pc[31:0] ^ 32'h1357_9bdf;
    p.exc_code = 4'h0;
    return p;
  endfunction

  task automatic idle();
    q_if.fe_queue_v_i    = 1'b0;
    q_if.fe_queue_yumi_i = 1'b0;
    q_if.commit_v_i      = 1'b0;
    q_if.roll_v_i        = 1'b0;
    q_if.clr_v_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic enq(input logic [38:0] pc);
    q_if.fe_queue_i   = mk(pc);
    q_if.fe_queue_v_i = 1'b1;
    tick();
  endtask

  task automatic check_head(input string tag, input logic [38:0] pc);
    check({tag, ".v"},  64'(q_if.fe_queue_v_o), 64'd1);
    check({tag, ".pc"}, 64'(q_if.fe_queue_o.pc), 64'(pc));
  endtask

  task automatic deq(input string tag, input logic [38:0] pc);
    #1;
    check_head(tag, pc);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      q_if.commit_v_i = 1'b1;
      tick();
    end
  endtask

  task automatic check_empty(input string tag);
    #1;
    check({tag, ".empty"}, 64'(q_if.empty_o), 64'd1);
    check({tag, ".v"},     64'(q_if.fe_queue_v_o), 64'd0);
    check({tag, ".ready"}, 64'(q_if.fe_queue_ready_o), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n_i       = 1'b0;
    q_if.fe_queue_i = mk(39'h0);
    idle();
    #12;
    check_empty("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset mid-stream
    for (int k = 0; k < 3; k++) enq(39'h0_0000_0100 + 39'(4 * k));
    check("mid.pre_v", 64'(q_if.fe_queue_v_o), 64'd1);
    #2 reset_n_i = 1'b0;
    check_empty("mid.async");
    #2 reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_empty("mid.after");

    // Fill to full
    for (int k = 0; k < 8; k++) enq(base_pc + 39'(4 * k));
    #1;
    check("fill.ready", 64'(q_if.fe_queue_ready_o), 64'd0);
    check("fill.empty", 64'(q_if.empty_o), 64'd0);
    q_if.fe_queue_i   = mk(39'h0_0000_0bad);
    q_if.fe_queue_v_i = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) deq($sformatf("fill.deq%0d", k), base_pc + 39'(4 * k));
    #1;
    check("full_deq.ready", 64'(q_if.fe_queue_ready_o), 64'd0);
    check("full_deq.v",     64'(q_if.fe_queue_v_o), 64'd0);
    q_if.commit_v_i = 1'b1;
    #1;
    check("full_commit.ready", 64'(q_if.fe_queue_ready_o), 64'd0);
    tick();
    check("after_commit.ready", 64'(q_if.fe_queue_ready_o), 64'd1);
    commit_n(7);
    check_empty("fill.drain");

    // Second lap across the pointer wrap
    for (int k = 8; k < 16; k++) enq(base_pc + 39'(4 * k));
    #1;
    check("wrap.ready", 64'(q_if.fe_queue_ready_o), 64'd0);
    for (int k = 8; k < 16; k++) deq($sformatf("wrap.deq%0d", k), base_pc + 39'(4 * k));
    commit_n(8);
    check_empty("wrap.drain");

    // Rollback: A-E, deq A-D, commit A-B, roll (with an ignored yumi)
    for (int k = 0; k < 5; k++) enq(39'h1000 + 39'(4 * k));
    for (int k = 0; k < 4; k++) deq($sformatf("roll.deq%0d", k), 39'h1000 + 39'(4 * k));
    commit_n(2);
    q_if.roll_v_i        = 1'b1;
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    for (int k = 2; k < 5; k++) deq($sformatf("roll.re%0d", k), 39'h1000 + 39'(4 * k));
    check("roll.end_v", 64'(q_if.fe_queue_v_o), 64'd0);
    commit_n(3);
    check_empty("roll.drain");

    // Roll with commit: rptr at D, cptr at B; next output is C
    for (int k = 0; k < 5; k++) enq(39'h2000 + 39'(4 * k));
    for (int k = 0; k < 3; k++) deq($sformatf("rc.deq%0d", k), 39'h2000 + 39'(4 * k));
    commit_n(1);
    q_if.roll_v_i   = 1'b1;
    q_if.commit_v_i = 1'b1;
    tick();
    for (int k = 2; k < 5; k++) deq($sformatf("rc.re%0d", k), 39'h2000 + 39'(4 * k));
    commit_n(3);
    check_empty("rc.drain");

    // Clear drops everything including a same-cycle enqueue
    for (int k = 0; k < 5; k++) enq(39'h3000 + 39'(4 * k));
    for (int k = 0; k < 2; k++) deq($sformatf("clr.deq%0d", k), 39'h3000 + 39'(4 * k));
    q_if.clr_v_i         = 1'b1;
    q_if.fe_queue_v_i    = 1'b1;
    q_if.fe_queue_i      = mk(39'h3ff0);
    q_if.fe_queue_yumi_i = 1'b1;
    q_if.commit_v_i      = 1'b1;
    #1;
    check("clr.ready", 64'(q_if.fe_queue_ready_o), 64'd0);
    tick();
    check_empty("clr.after");
    enq(39'h4000);
    deq("clr.new", 39'h4000);
    commit_n(1);
    check_empty("clr.drain");

    // Enqueue into an empty queue: forwarded same cycle only with bypass
    q_if.fe_queue_i   = mk(39'h5000);
    q_if.fe_queue_v_i = 1'b1;
`ifdef BP_FE_QUEUE_BYPASS_EN
    q_if.fe_queue_yumi_i = 1'b1;
    #1;
    check_head("byp.same", 39'h5000);
    tick();
    check("byp.after_v", 64'(q_if.fe_queue_v_o), 64'd0);
    check("byp.after_empty", 64'(q_if.empty_o), 64'd0);
`else
    #1;
    check("byp.same_v", 64'(q_if.fe_queue_v_o), 64'd0);
    tick();
    deq("byp.next", 39'h5000);
`endif
    commit_n(1);
    check_empty("byp.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
